// File: rtl/sample_pkg.sv
// Shared definitions for the acquisition stage and the memory-dump sender.
package sample_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 8;
   localparam int unsigned DEFAULT_ADDR_WIDTH = 16;
   localparam int unsigned DEFAULT_DIV_WIDTH  = 16;

   // The sender compares its read address against CAPTURE_DEPTH-1.
   localparam int unsigned CAPTURE_DEPTH = 2 ** DEFAULT_ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      ARMED     = 2'b01,
      CAPTURING = 2'b10,
      DONE      = 2'b11
   } captureState_e;

   // Clocks from entering CAPTURING up to and including the DONE cycle.
   function automatic int unsigned captureCycles(input int unsigned depth,
                                                 input int unsigned divider);
      return depth * (divider + 1) + 2;
   endfunction

endpackage

// File: rtl/sync2.sv
// Parameterised-width two-flop synchroniser with synchronous active-high reset.
module sync2 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             iClock,
   input  logic             iReset,
   input  logic [WIDTH-1:0] iData,
   output logic [WIDTH-1:0] oData
);

   logic [WIDTH-1:0] stage;

   always_ff @(posedge iClock) begin
      if (iReset) begin
         stage <= '0;
         oData <= '0;
      end else begin
         stage <= iData;
         oData <= stage;
      end
   end

endmodule

// File: rtl/sample_capture.sv
// Arms, optionally waits for a trigger, then writes 2^ADDR_WIDTH samples to the sample RAM.
// Optional trigger compare enabled by defining SAMPLE_CAPTURE_TRIGGER_EN.
module sample_capture
   import sample_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int unsigned DIV_WIDTH  = DEFAULT_DIV_WIDTH
) (
   input  logic                  iClock,
   input  logic                  iReset,
   input  logic                  iArm,
   input  logic                  iAbort,
   input  logic [DATA_WIDTH-1:0] iSamples,
   input  logic [DIV_WIDTH-1:0]  iDivider,
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
   input  logic [DATA_WIDTH-1:0] iTrigMask,
   input  logic [DATA_WIDTH-1:0] iTrigValue,
`endif
   output logic [ADDR_WIDTH-1:0] oWrAddress,
   output logic [DATA_WIDTH-1:0] oWrData,
   output logic                  oWrEnable,
   output logic                  oBusy,
   output logic                  oFinished
);

   captureState_e         state;
   logic [DIV_WIDTH-1:0]  divCount;
   logic [DATA_WIDTH-1:0] syncS;
   logic                  triggerHit;
   logic                  divHit;
   logic                  lastAddr;

   sync2 #(
      .WIDTH(DATA_WIDTH)
   ) uSync (
      .iClock(iClock),
      .iReset(iReset),
      .iData (iSamples),
      .oData (syncS)
   );

`ifdef SAMPLE_CAPTURE_TRIGGER_EN
   assign triggerHit = ((syncS ^ iTrigValue) & iTrigMask) == '0;
`else
   assign triggerHit = 1'b1;
`endif

   assign divHit   = (divCount == iDivider);
   assign lastAddr = (oWrAddress == '1);

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state      <= IDLE;
         oWrAddress <= '0;
         oWrData    <= '0;
         oWrEnable  <= 1'b0;
         oBusy      <= 1'b0;
         oFinished  <= 1'b0;
         divCount   <= '0;
      end else if (iAbort && (state != IDLE)) begin
         // Abort drops any compare result of this cycle, so no trailing write.
         state      <= IDLE;
         oWrAddress <= '0;
         oWrEnable  <= 1'b0;
         oBusy      <= 1'b0;
         oFinished  <= 1'b0;
         divCount   <= '0;
      end else begin
         oWrEnable <= 1'b0;
         oFinished <= 1'b0;
         unique case (state)
            IDLE: begin
               oWrAddress <= '0;
               divCount   <= '0;
               if (iArm) begin
                  state <= ARMED;
                  oBusy <= 1'b1;
               end
            end
            ARMED: begin
               if (triggerHit) begin
                  state    <= CAPTURING;
                  divCount <= '0;
               end
            end
            CAPTURING: begin
               if (oWrEnable && lastAddr) begin
                  // Final word is on the bus now; address holds, never wraps.
                  state     <= DONE;
                  oBusy     <= 1'b0;
                  oFinished <= 1'b1;
               end else begin
                  if (oWrEnable) begin
                     oWrAddress <= oWrAddress + ADDR_WIDTH'(1);
                  end
                  if (divHit) begin
                     divCount  <= '0;
                     oWrEnable <= 1'b1;
                     oWrData   <= syncS;
                  end else begin
                     divCount <= divCount + DIV_WIDTH'(1);
                  end
               end
            end
            DONE: begin
               state      <= IDLE;
               oWrAddress <= '0;
            end
         endcase
      end
   end

endmodule
